// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates a single-port memory between instruction fetch and
//               data access. Data wins ties, the requester just served is
//               skipped at re-arbitration, and a flushed fetch completes
//               without a ready pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_ready,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_if,
    output logic          stall_mem
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    // Counter value of the last cycle of an access.
    localparam logic [3:0] c_LAST_CNT = 4'(MEM_LAT - 1);

    state_t        r_state;
    state_t        w_nextState;
    logic [3:0]    r_cnt;
    logic [3:0]    w_nextCnt;
    logic          r_kill;
    logic          w_nextKill;
    logic          w_nextMemEn;
    logic          w_nextMemWe;
    logic [AW-1:0] w_nextMemAddr;
    logic [DW-1:0] w_nextMemWdata;
    logic          w_isFinal;
    logic          w_startD;
    logic          w_startI;
    logic          w_goIdle;

    assign w_isFinal = (r_state != IDLE) && (r_cnt == c_LAST_CNT);

    // A flush seen in the final cycle suppresses the pulse before the
    // registered kill flag could catch it.
    assign if_ready  = (r_state == BUSY_I) && w_isFinal && !r_kill && !if_flush;
    assign d_ready   = (r_state == BUSY_D) && w_isFinal;
    assign if_rdata  = if_ready ? mem_rdata : '0;
    assign d_rdata   = d_ready  ? mem_rdata : '0;
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = d_req  & ~d_ready;

    // Next-state arbitration: grant from IDLE, count in BUSY, and at the final
    // cycle hand over to the other requester only (no idle bubble).
    always_comb begin
        w_nextState    = r_state;
        w_nextCnt      = r_cnt;
        w_nextKill     = r_kill;
        w_nextMemEn    = mem_en;
        w_nextMemWe    = mem_we;
        w_nextMemAddr  = mem_addr;
        w_nextMemWdata = mem_wdata;
        w_startD       = 1'b0;
        w_startI       = 1'b0;
        w_goIdle       = 1'b0;

        case (r_state)
            IDLE: begin
                if (d_req) begin
                    w_startD = 1'b1;
                end else if (if_req && !if_flush) begin
                    w_startI = 1'b1;
                end
            end
            BUSY_I: begin
                if (w_isFinal) begin
                    if (d_req) begin
                        w_startD = 1'b1;
                    end else begin
                        w_goIdle = 1'b1;
                    end
                end else begin
                    w_nextCnt  = r_cnt + 4'd1;
                    w_nextKill = r_kill | if_flush;
                end
            end
            BUSY_D: begin
                if (w_isFinal) begin
                    if (if_req && !if_flush) begin
                        w_startI = 1'b1;
                    end else begin
                        w_goIdle = 1'b1;
                    end
                end else begin
                    w_nextCnt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_goIdle = 1'b1;
            end
        endcase

        if (w_startD) begin
            w_nextState    = BUSY_D;
            w_nextCnt      = 4'd0;
            w_nextKill     = 1'b0;
            w_nextMemEn    = 1'b1;
            w_nextMemWe    = d_we;
            w_nextMemAddr  = d_addr;
            w_nextMemWdata = d_wdata;
        end else if (w_startI) begin
            w_nextState    = BUSY_I;
            w_nextCnt      = 4'd0;
            w_nextKill     = 1'b0;
            w_nextMemEn    = 1'b1;
            w_nextMemWe    = 1'b0;
            w_nextMemAddr  = if_addr;
        end else if (w_goIdle) begin
            w_nextState    = IDLE;
            w_nextKill     = 1'b0;
            w_nextMemEn    = 1'b0;
            w_nextMemWe    = 1'b0;
        end
    end

    // State, counter, kill flag and memory bus registers; reset aborts any access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_kill    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            r_state   <= w_nextState;
            r_cnt     <= w_nextCnt;
            r_kill    <= w_nextKill;
            mem_en    <= w_nextMemEn;
            mem_we    <= w_nextMemWe;
            mem_addr  <= w_nextMemAddr;
            mem_wdata <= w_nextMemWdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter (MEM_LAT=2 and MEM_LAT=1
//               instances) with a queue of expected completions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int LAT = 2;

    typedef struct packed {
        logic        isData;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    // MEM_LAT=2 instance
    logic        if_req, if_flush, if_ready, d_req, d_we, d_ready;
    logic        mem_en, mem_we, stall_if, stall_mem;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    // MEM_LAT=1 instance
    logic        if_req1, if_flush1, if_ready1, d_req1, d_we1, d_ready1;
    logic        mem_en1, mem_we1, stall_if1, stall_mem1;
    logic [31:0] if_addr1, if_rdata1, d_addr1, d_wdata1, d_rdata1;
    logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

    // Memory model: read data is a fixed function of the address.
    function automatic logic [31:0] memVal(input logic [31:0] a);
        return a ^ 32'h0000_1274;
    endfunction

    assign mem_rdata  = memVal(mem_addr);
    assign mem_rdata1 = memVal(mem_addr1);

    mem_arbiter #(.MEM_LAT(2), .AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    mem_arbiter #(.MEM_LAT(1), .AW(32), .DW(32)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req1), .if_addr(if_addr1), .if_flush(if_flush1),
        .if_ready(if_ready1), .if_rdata(if_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_ready(d_ready1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
        .stall_if(stall_if1), .stall_mem(stall_mem1)
    );

    int   nChecks = 0;
    int   nFail   = 0;
    exp_t sb[$];
    exp_t e;

    function automatic exp_t mk(input logic isD, input logic [31:0] a);
        exp_t t;
        t.isData = isD;
        t.rdata  = memVal(a);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 1'b1; if_flush = 1'b0; if_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0; d_wdata = 32'h0;
        if_req1 = 1'b0; if_flush1 = 1'b0; if_addr1 = 32'h0;
        d_req1 = 1'b0; d_we1 = 1'b0; d_addr1 = 32'h0; d_wdata1 = 32'h0;
        tick(); tick();
        nChecks++; if (mem_en !== 1'b0) begin nFail++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
        nChecks++; if (mem_we !== 1'b0) begin nFail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        nChecks++; if (mem_addr !== 32'h0) begin nFail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        nChecks++; if (mem_wdata !== 32'h0) begin nFail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        nChecks++; if ({if_ready, d_ready} !== 2'b00) begin nFail++; $display("FAIL reset_ready: got %b want 00", {if_ready, d_ready}); end
        nChecks++; if ({stall_if, stall_mem} !== 2'b11) begin nFail++; $display("FAIL reset_stall: got %b want 11", {stall_if, stall_mem}); end
        nChecks++; if (mem_en1 !== 1'b0) begin nFail++; $display("FAIL reset_mem_en1: got %b want 0", mem_en1); end
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_fetch();
        if_addr = 32'h40; if_req = 1'b1;
        sb.push_back(mk(1'b0, 32'h40));
        tick();
        nChecks++; if ({mem_en, mem_we} !== 2'b10) begin nFail++; $display("FAIL fetch_grant_en_we: got %b want 10", {mem_en, mem_we}); end
        nChecks++; if (mem_addr !== 32'h40) begin nFail++; $display("FAIL fetch_addr: got %h want 40", mem_addr); end
        nChecks++; if ({if_ready, stall_if} !== 2'b01) begin nFail++; $display("FAIL fetch_wait: ready,stall got %b want 01", {if_ready, stall_if}); end
        tick();
        e = sb.pop_front();
        nChecks++; if ({if_ready, stall_if} !== 2'b10) begin nFail++; $display("FAIL fetch_ready: ready,stall got %b want 10", {if_ready, stall_if}); end
        nChecks++; if (if_rdata !== e.rdata) begin nFail++; $display("FAIL fetch_rdata: got %h want %h", if_rdata, e.rdata); end
        nChecks++; if (mem_en !== 1'b1) begin nFail++; $display("FAIL fetch_en_cycle2: got %b want 1", mem_en); end
        if_req = 1'b0;
        tick();
        nChecks++; if ({mem_en, if_ready} !== 2'b00) begin nFail++; $display("FAIL fetch_done_idle: en,ready got %b want 00", {mem_en, if_ready}); end
        nChecks++; if (if_rdata !== 32'h0) begin nFail++; $display("FAIL fetch_rdata_zero: got %h want 0", if_rdata); end
    endtask

    task automatic test_priority();
        if_addr = 32'h80; if_req = 1'b1;
        d_addr = 32'h100; d_we = 1'b1; d_wdata = 32'hAA; d_req = 1'b1;
        sb.push_back(mk(1'b1, 32'h100));
        sb.push_back(mk(1'b0, 32'h80));
        tick();
        nChecks++; if ({mem_en, mem_we} !== 2'b11) begin nFail++; $display("FAIL prio_d_first_en_we: got %b want 11", {mem_en, mem_we}); end
        nChecks++; if (mem_addr !== 32'h100) begin nFail++; $display("FAIL prio_d_addr: got %h want 100", mem_addr); end
        nChecks++; if (mem_wdata !== 32'hAA) begin nFail++; $display("FAIL prio_d_wdata: got %h want aa", mem_wdata); end
        nChecks++; if (d_rdata !== 32'h0) begin nFail++; $display("FAIL prio_d_rdata_zero: got %h want 0", d_rdata); end
        nChecks++; if ({stall_mem, stall_if} !== 2'b11) begin nFail++; $display("FAIL prio_stalls: got %b want 11", {stall_mem, stall_if}); end
        tick();
        e = sb.pop_front();
        nChecks++; if ({d_ready, if_ready} !== 2'b10) begin nFail++; $display("FAIL prio_d_ready: d,i got %b want 10", {d_ready, if_ready}); end
        nChecks++; if (d_rdata !== e.rdata) begin nFail++; $display("FAIL prio_d_rdata: got %h want %h", d_rdata, e.rdata); end
        d_req = 1'b0; d_we = 1'b0;
        tick();
        nChecks++; if ({mem_en, mem_we} !== 2'b10) begin nFail++; $display("FAIL prio_i_no_bubble: en,we got %b want 10", {mem_en, mem_we}); end
        nChecks++; if (mem_addr !== 32'h80) begin nFail++; $display("FAIL prio_i_addr: got %h want 80", mem_addr); end
        tick();
        e = sb.pop_front();
        nChecks++; if (if_ready !== 1'b1) begin nFail++; $display("FAIL prio_i_ready: got %b want 1", if_ready); end
        nChecks++; if (if_rdata !== e.rdata) begin nFail++; $display("FAIL prio_i_rdata: got %h want %h", if_rdata, e.rdata); end
        if_req = 1'b0;
        tick();
        nChecks++; if (mem_en !== 1'b0) begin nFail++; $display("FAIL prio_idle: en got %b want 0", mem_en); end
    endtask

    task automatic test_contention();
        int served = 0;
        int gap    = 0;
        if_addr = 32'h200; d_addr = 32'h300; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 8; i++) sb.push_back(mk((i % 2) == 0, (i % 2) == 0 ? 32'h300 : 32'h200));
        for (int cyc = 0; cyc < 40 && served < 8; cyc++) begin
            tick();
            gap++;
            if (d_ready || if_ready) begin
                e = sb.pop_front();
                nChecks++; if ({d_ready, if_ready} !== {e.isData, ~e.isData}) begin nFail++; $display("FAIL contention_order #%0d: d,i got %b want %b", served, {d_ready, if_ready}, {e.isData, ~e.isData}); end
                nChecks++; if ((e.isData ? d_rdata : if_rdata) !== e.rdata) begin nFail++; $display("FAIL contention_rdata #%0d: got %h want %h", served, (e.isData ? d_rdata : if_rdata), e.rdata); end
                nChecks++; if (gap !== LAT) begin nFail++; $display("FAIL contention_gap #%0d: got %0d want %0d", served, gap, LAT); end
                gap = 0;
                served++;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        nChecks++; if (served !== 8) begin nFail++; $display("FAIL contention_count: got %0d want 8", served); end
        sb.delete();
        tick(); tick();
    endtask

    task automatic test_flush();
        if_addr = 32'h500; if_req = 1'b1; if_flush = 1'b1;
        tick();
        nChecks++; if (mem_en !== 1'b0) begin nFail++; $display("FAIL flush_idle_block: en got %b want 0", mem_en); end
        if_flush = 1'b0;
        tick();
        nChecks++; if ({mem_en, mem_addr} !== {1'b1, 32'h500}) begin nFail++; $display("FAIL flush_grant: en,addr got %b,%h want 1,500", mem_en, mem_addr); end
        if_flush = 1'b1; if_addr = 32'h600;
        tick();
        if_flush = 1'b0;
        #1;
        nChecks++; if ({mem_en, if_ready} !== 2'b10) begin nFail++; $display("FAIL flush_killed: en,ready got %b want 10", {mem_en, if_ready}); end
        tick();
        nChecks++; if ({mem_en, if_ready} !== 2'b00) begin nFail++; $display("FAIL flush_back_idle: en,ready got %b want 00", {mem_en, if_ready}); end
        sb.push_back(mk(1'b0, 32'h600));
        tick();
        nChecks++; if ({mem_en, mem_addr} !== {1'b1, 32'h600}) begin nFail++; $display("FAIL flush_new_pc: en,addr got %b,%h want 1,600", mem_en, mem_addr); end
        tick();
        e = sb.pop_front();
        nChecks++; if ({if_ready, if_rdata} !== {1'b1, e.rdata}) begin nFail++; $display("FAIL flush_new_ready: ready,rdata got %b,%h want 1,%h", if_ready, if_rdata, e.rdata); end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        d_addr = 32'h700; d_we = 1'b1; d_wdata = 32'h55; d_req = 1'b1;
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        nChecks++; if ({mem_en, mem_we, d_ready} !== 3'b000) begin nFail++; $display("FAIL rstmid_async: en,we,ready got %b want 000", {mem_en, mem_we, d_ready}); end
        nChecks++; if (mem_addr !== 32'h0) begin nFail++; $display("FAIL rstmid_addr: got %h want 0", mem_addr); end
        nChecks++; if (stall_mem !== 1'b1) begin nFail++; $display("FAIL rstmid_stall: got %b want 1", stall_mem); end
        tick();
        nChecks++; if (mem_en !== 1'b0) begin nFail++; $display("FAIL rstmid_held: en got %b want 0", mem_en); end
        rst_n = 1'b1;
        sb.push_back(mk(1'b1, 32'h700));
        tick();
        nChecks++; if ({mem_en, mem_we, d_ready} !== 3'b110) begin nFail++; $display("FAIL rstmid_regrant: en,we,ready got %b want 110", {mem_en, mem_we, d_ready}); end
        nChecks++; if ({mem_addr, mem_wdata} !== {32'h700, 32'h55}) begin nFail++; $display("FAIL rstmid_bus: addr,wdata got %h,%h want 700,55", mem_addr, mem_wdata); end
        tick();
        e = sb.pop_front();
        nChecks++; if ({d_ready, d_rdata} !== {1'b1, e.rdata}) begin nFail++; $display("FAIL rstmid_done: ready,rdata got %b,%h want 1,%h", d_ready, d_rdata, e.rdata); end
        d_req = 1'b0; d_we = 1'b0;
        tick();
    endtask

    task automatic test_lat1();
        int served = 0;
        int used   = 0;
        d_addr1 = 32'h10; d_we1 = 1'b0; d_req1 = 1'b1;
        if_addr1 = 32'h20; if_req1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(mk(1'b1, 32'h10 + 32'(4 * k)));
            sb.push_back(mk(1'b0, 32'h20 + 32'(4 * k)));
        end
        for (int cyc = 0; cyc < 12 && served < 6; cyc++) begin
            tick();
            used++;
            if (d_ready1 || if_ready1) begin
                e = sb.pop_front();
                nChecks++; if ({d_ready1, if_ready1} !== {e.isData, ~e.isData}) begin nFail++; $display("FAIL lat1_order #%0d: d,i got %b want %b", served, {d_ready1, if_ready1}, {e.isData, ~e.isData}); end
                nChecks++; if ((e.isData ? d_rdata1 : if_rdata1) !== e.rdata) begin nFail++; $display("FAIL lat1_rdata #%0d: got %h want %h", served, (e.isData ? d_rdata1 : if_rdata1), e.rdata); end
                if (e.isData) d_addr1 = d_addr1 + 32'd4;
                else if_addr1 = if_addr1 + 32'd4;
                served++;
            end
        end
        d_req1 = 1'b0; if_req1 = 1'b0;
        nChecks++; if (served !== 6) begin nFail++; $display("FAIL lat1_count: got %0d want 6", served); end
        nChecks++; if (used !== 6) begin nFail++; $display("FAIL lat1_throughput: cycles got %0d want 6", used); end
        sb.delete();
        tick();
        nChecks++; if (mem_en1 !== 1'b0) begin nFail++; $display("FAIL lat1_idle: en got %b want 0", mem_en1); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_priority();
        test_contention();
        test_flush();
        test_reset_mid();
        test_lat1();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "time limit reached");
    end

endmodule
`default_nettype wire
